// File: rtl/ks_add_pkg.sv
// Shared constants, result-entry sizing and a pointer-width helper for the
// Kogge-Stone adder flow-control shell. Optional feature macro: ADD_OVF_EN.
package ks_add_pkg;

  localparam int unsigned KS_WIDTH      = 64;
  localparam int unsigned KS_ADD_LAT    = 3;
  localparam int unsigned KS_FIFO_DEPTH = 8;
  localparam int unsigned KS_COUT_BITS  = 1;

`ifdef ADD_OVF_EN
  localparam int unsigned KS_OVF_BITS = 1;
`else
  localparam int unsigned KS_OVF_BITS = 0;
`endif

  // Smallest pointer width able to index depth entries (at least 1 bit)
  function automatic int unsigned ks_ptr_w(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(depth)) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

  // Stored result entry: {[ovf], cout, sum}
  function automatic int unsigned ks_entry_w(input int unsigned width);
    return width + KS_COUT_BITS + KS_OVF_BITS;
  endfunction

  typedef struct packed {
    logic                cout;
    logic [KS_WIDTH-1:0] sum;
  } ks_result_t;

endpackage

// File: rtl/ks_add_flow_ctrl_if.sv
// Upstream operand and downstream result handshakes of the adder shell.
interface ks_add_flow_ctrl_if
  import ks_add_pkg::*;
#(
  parameter int unsigned WIDTH = KS_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_cin;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  // Producer/consumer side
  modport master (
    output in_valid, in_a, in_b, in_cin, out_ready,
    input  in_ready, out_valid, out_sum, out_cout, out_ovf
  );

  // Flow-control shell side
  modport slave (
    input  in_valid, in_a, in_b, in_cin, out_ready,
    output in_ready, out_valid, out_sum, out_cout, out_ovf
  );

endinterface

// File: rtl/ks_result_fifo.sv
// Synchronous first-word-fall-through result FIFO; DEPTH must be a power of two.
module ks_result_fifo
  import ks_add_pkg::*;
#(
  parameter  int unsigned DATA_W = KS_WIDTH + 1,
  parameter  int unsigned DEPTH  = KS_FIFO_DEPTH,
  localparam int unsigned PTR_W  = ks_ptr_w(DEPTH),
  localparam int unsigned CNT_W  = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] rdata,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              valid_q, valid_d;
  logic              pop_eff;

  // Next-state: write at tail, advance head on a pop of a non-empty FIFO
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    pop_eff  = pop && valid_q;
    if (push) begin
      mem_d[wr_ptr_q] = wdata;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop_eff) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push) - CNT_W'(pop_eff);
    valid_d = (count_d != '0);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
    end
  end

  // Credit accounting upstream must make overflow unreachable
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (count_q <= CNT_W'(DEPTH));
      assert (!(push && !pop_eff && (count_q == CNT_W'(DEPTH))));
    end
  end

  assign valid = valid_q;
  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/ks_add_flow_ctrl.sv
// Valid/ready shell around the pipelined Kogge-Stone adder: issue register,
// valid-tag shift register tracking the adder pipeline, credit-based in_ready
// and a result FIFO absorbing consumer back-pressure.
// Optional feature macro: ADD_OVF_EN (signed overflow flag per result).
module ks_add_flow_ctrl
  import ks_add_pkg::*;
#(
  parameter int unsigned WIDTH      = KS_WIDTH,
  parameter int unsigned ADD_LAT    = KS_ADD_LAT,
  parameter int unsigned FIFO_DEPTH = KS_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             rst,
  ks_add_flow_ctrl_if.slave bus,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout
);

  localparam int unsigned CNT_W   = ks_ptr_w(FIFO_DEPTH) + 1;
  localparam int unsigned ENTRY_W = ks_entry_w(WIDTH);
  localparam int unsigned CRED_W  = CNT_W + 8;

  logic [WIDTH-1:0]   add_a_q, add_a_d;
  logic [WIDTH-1:0]   add_b_q, add_b_d;
  logic               add_cin_q, add_cin_d;
  logic               issue_vld_q, issue_vld_d;
  logic [ADD_LAT-1:0] vld_sr_q, vld_sr_d;
  logic               in_ready_q, in_ready_d;

  logic               accept;
  logic               push;
  logic               pop_eff;
  logic [CRED_W-1:0]  count_nxt;
  logic [CRED_W-1:0]  inflight_nxt;

  logic               fifo_valid;
  logic [ENTRY_W-1:0] fifo_wdata;
  logic [ENTRY_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]   fifo_count;

  assign accept  = bus.in_valid && in_ready_q;
  assign push    = vld_sr_q[ADD_LAT-1];
  assign pop_eff = bus.out_ready && fifo_valid;

  // Issue register: capture operands on accept, otherwise hold them
  always_comb begin
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    issue_vld_d = accept;
    if (accept) begin
      add_a_d   = bus.in_a;
      add_b_d   = bus.in_b;
      add_cin_d = bus.in_cin;
    end
  end

  // Valid tag follows the operands through the adder stages
  always_comb begin
    vld_sr_d = ADD_LAT'({vld_sr_q, issue_vld_q});
  end

  // Credits: results stored plus results still travelling must fit the FIFO
  always_comb begin
    count_nxt    = CRED_W'(fifo_count) + CRED_W'(push) - CRED_W'(pop_eff);
    inflight_nxt = CRED_W'($countones(vld_sr_d)) + CRED_W'(issue_vld_d);
    in_ready_d   = (count_nxt + inflight_nxt) < CRED_W'(FIFO_DEPTH);
  end

  // Issue, tracking and credit state
  always_ff @(posedge clk) begin
    if (rst) begin
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      issue_vld_q <= 1'b0;
      vld_sr_q    <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      issue_vld_q <= issue_vld_d;
      vld_sr_q    <= vld_sr_d;
      in_ready_q  <= in_ready_d;
    end
  end

`ifdef ADD_OVF_EN
  logic [ADD_LAT-1:0][1:0] msb_sr_q, msb_sr_d;
  logic                    ovf_wr;

  // Operand sign bits ride along with the valid tag
  always_comb begin
    msb_sr_d[0] = {add_a_q[WIDTH-1], add_b_q[WIDTH-1]};
    for (int i = 1; i < int'(ADD_LAT); i++) msb_sr_d[i] = msb_sr_q[i-1];
    ovf_wr     = (msb_sr_q[ADD_LAT-1][1] == msb_sr_q[ADD_LAT-1][0]) &&
                 (add_sum[WIDTH-1] != msb_sr_q[ADD_LAT-1][1]);
    fifo_wdata = {ovf_wr, add_cout, add_sum};
  end

  // Sign-bit shift register
  always_ff @(posedge clk) begin
    if (rst) msb_sr_q <= '0;
    else     msb_sr_q <= msb_sr_d;
  end

  assign bus.out_ovf = fifo_rdata[ENTRY_W-1];
`else
  // Result entry without overflow tracking
  always_comb begin
    fifo_wdata = {add_cout, add_sum};
  end

  assign bus.out_ovf = 1'b0;
`endif

  ks_result_fifo #(
    .DATA_W (ENTRY_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (fifo_wdata),
    .pop   (bus.out_ready),
    .valid (fifo_valid),
    .rdata (fifo_rdata),
    .count (fifo_count)
  );

  assign add_a        = add_a_q;
  assign add_b        = add_b_q;
  assign add_cin      = add_cin_q;
  assign bus.in_ready = in_ready_q;
  assign bus.out_valid = fifo_valid;
  assign bus.out_sum   = fifo_rdata[WIDTH-1:0];
  assign bus.out_cout  = fifo_rdata[WIDTH];

endmodule

// File: tb/tb_ks_add_flow_ctrl.sv
// Bench for ks_add_flow_ctrl with a behavioural pipelined adder standing in
// for ks_adder_64. Honours ADD_OVF_EN when defined.
module tb_ks_add_flow_ctrl;
  import ks_add_pkg::*;

  localparam int unsigned W     = KS_WIDTH;
  localparam int unsigned LAT   = KS_ADD_LAT;
  localparam int unsigned DEPTH = KS_FIFO_DEPTH;
`ifdef ADD_OVF_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] add_a, add_b, add_sum;
  logic         add_cin, add_cout;

  always #5 clk = ~clk;

  ks_add_flow_ctrl_if #(.WIDTH(W)) bus ();

  ks_add_flow_ctrl #(
    .WIDTH      (W),
    .ADD_LAT    (LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout)
  );

  // Adder stand-in: LAT register stages, no stall
  logic [W:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= {1'b0, add_a} + {1'b0, add_b} + (W+1)'(add_cin);
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign {add_cout, add_sum} = pipe[LAT-1];

  int n_checks = 0;
  int n_fail   = 0;
  int n_pops   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input logic [W:0] got, input logic [W:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    chk(name, {{W{1'b0}}, got}, {{W{1'b0}}, exp});
  endtask

  task automatic chki(input string name, input int got, input int exp);
    chk(name, (W+1)'(got), (W+1)'(exp));
  endtask

  // Behavioural model: ordered results, each visible from a known cycle
  typedef struct {
    ks_result_t res;
    logic       ovf;
    int         rc;
  } exp_t;

  exp_t mq[$];
  int   outstanding = 0;
  bit   rst_prev    = 1'b1;

  function automatic exp_t model_add(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input logic c, input int rc);
    exp_t       e;
    logic [W:0] full;
    full       = {1'b0, a} + {1'b0, b} + (W+1)'(c);
    e.res.sum  = full[W-1:0];
    e.res.cout = full[W];
    e.ovf      = EXP_OVF && (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    e.rc       = rc;
    return e;
  endfunction

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) n_pops++;
  end

  // Compare DUT against the model every cycle, then advance the model
  always @(negedge clk) begin
    bit exp_ready;
    bit exp_valid;
    if (cyc > 0) begin
      exp_ready = !rst_prev && (outstanding < int'(DEPTH));
      exp_valid = (mq.size() > 0) && (mq[0].rc <= cyc);
      chk1("model_in_ready", bus.in_ready, exp_ready);
      chk1("model_out_valid", bus.out_valid, exp_valid);
      if (exp_valid && bus.out_valid) begin
        chk("model_out_sum", {1'b0, bus.out_sum}, {1'b0, mq[0].res.sum});
        chk1("model_out_cout", bus.out_cout, mq[0].res.cout);
        chk1("model_out_ovf", bus.out_ovf, mq[0].ovf);
      end
      if (rst) begin
        mq.delete();
        outstanding = 0;
        rst_prev    = 1'b1;
      end else begin
        if (bus.out_ready && exp_valid) begin
          void'(mq.pop_front());
          outstanding--;
        end
        if (bus.in_valid && exp_ready) begin
          mq.push_back(model_add(bus.in_a, bus.in_b, bus.in_cin, cyc + 1 + int'(LAT) + 1));
          outstanding++;
        end
        rst_prev = 1'b0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic c);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_cin   = c;
  endtask

  // Returns the number of negedges until out_valid, 0 on timeout
  task automatic wait_out(input int max_cyc, output int n);
    n = 0;
    for (int i = 1; i <= max_cyc; i++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        n = i;
        break;
      end
    end
    if (n == 0) $display("FAIL wait_out: out_valid not seen within %0d cycles", max_cyc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int           lat;
    int           n_acc;
    int           p0;
    logic [W-1:0] va, vb;
    logic [W-1:0] tab_a [4];
    logic [W-1:0] tab_b [4];

    tab_a[0] = '1;                    tab_b[0] = '0;
    tab_a[1] = '0;                    tab_b[1] = '0;
    tab_a[2] = 64'h8000_0000_0000_0000; tab_b[2] = 64'h8000_0000_0000_0000;
    tab_a[3] = 64'h7FFF_FFFF_FFFF_FFFF; tab_b[3] = 64'h7FFF_FFFF_FFFF_FFFF;

    drive(1'b0, '0, '0, 1'b0);
    bus.out_ready = 1'b1;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk1("rst_in_ready", bus.in_ready, 1'b0);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_out_sum", {1'b0, bus.out_sum}, '0);
    chk1("rst_out_cout", bus.out_cout, 1'b0);
    chk1("rst_out_ovf", bus.out_ovf, 1'b0);
    chk("rst_add_a", {1'b0, add_a}, '0);
    chk("rst_add_b", {1'b0, add_b}, '0);
    chk1("rst_add_cin", add_cin, 1'b0);
    step();
    rst = 1'b0;
    step();
    chk1("rst_release_in_ready", bus.in_ready, 1'b1);

    // T1: all-ones + 1 wraps to zero with carry out, 5 clocks to out_valid
    drive(1'b1, '1, 64'd1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    wait_out(12, lat);
    chki("t1_latency", lat, 5);
    chk("t1_sum", {1'b0, bus.out_sum}, '0);
    chk1("t1_cout", bus.out_cout, 1'b1);
    step();
    repeat (2) step();

    // T2: 100 back-to-back operations with the consumer always ready
    p0 = n_pops;
    for (int i = 0; i < 100; i++) begin
      if (i < 4) begin
        va = tab_a[i];
        vb = tab_b[i];
      end else begin
        va = 64'h0123_4567_89AB_CDEF * 64'(i + 1);
        vb = {va[31:0], va[63:32]} ^ 64'(i);
      end
      drive(1'b1, va, vb, 1'(i & 1));
      chk1("t2_in_ready", bus.in_ready, 1'b1);
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    repeat (8) step();
    chki("t2_results", n_pops - p0, 100);

    // T3: consumer stalled, exactly DEPTH operations accepted
    bus.out_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 64'(100 + 3 * i), 64'(i), 1'b1);
      if (bus.in_ready) n_acc++;
      step();
    end
    chki("t3_accepts", n_acc, 8);
    chk1("t3_in_ready_full", bus.in_ready, 1'b0);
    chk1("t3_out_valid_held", bus.out_valid, 1'b1);

    // T4: one pop frees a credit only from the following cycle
    drive(1'b1, 64'hDEAD_BEEF, 64'h1111, 1'b0);
    bus.out_ready = 1'b1;
    chk1("t4_in_ready_pop_cycle", bus.in_ready, 1'b0);
    step();
    bus.out_ready = 1'b0;
    chk1("t4_in_ready_after_pop", bus.in_ready, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    chk1("t4_in_ready_refilled", bus.in_ready, 1'b0);
    repeat (6) step();
    p0 = n_pops;
    bus.out_ready = 1'b1;
    repeat (12) step();
    chki("t4_drained", n_pops - p0, 8);
    chk1("t4_empty", bus.out_valid, 1'b0);

    // T5: reset with three operations in flight discards them
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 64'(1000 + i), 64'(2000 + i), 1'(i & 1));
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk1("t5_no_out_valid", bus.out_valid, 1'b0);
    end
    step();
    drive(1'b1, 64'd5, 64'd7, 1'b1);
    step();
    drive(1'b0, '0, '0, 1'b0);
    wait_out(12, lat);
    chki("t5_latency", lat, 5);
    chk("t5_sum", {1'b0, bus.out_sum}, 65'd13);
    chk1("t5_cout", bus.out_cout, 1'b0);
    step();

    // T6: signed overflow flag
    drive(1'b1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    wait_out(12, lat);
    chk("t6_pos_sum", {1'b0, bus.out_sum}, {1'b0, 64'h8000_0000_0000_0000});
    chk1("t6_pos_cout", bus.out_cout, 1'b0);
    chk1("t6_pos_ovf", bus.out_ovf, EXP_OVF);
    step();
    drive(1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    wait_out(12, lat);
    chk("t6_neg_sum", {1'b0, bus.out_sum}, '0);
    chk1("t6_neg_cout", bus.out_cout, 1'b1);
    chk1("t6_neg_ovf", bus.out_ovf, EXP_OVF);
    step();

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
